uart_baud_gen: RTL and testbench
================================

// Module: uart_baud_gen
// PURPOSE
//  Runtime-programmable baud-rate tick generator for the UART TX/RX datapaths.
//  A prescaler produces a 1-cycle oversample strobe (rx_os_tick) at OSR x baud for the receiver.
//  A separate OSR-count stage produces a 1x baud strobe (tx_tick) for the transmitter.
//  The divisor loads at run time without a rebuild. RX phase can be restarted on a start-bit edge.
// PARAMETERS
//  DIV_W    16   prescaler width; divisor range 1..2**DIV_W-1
//  OSR      16   oversample ratio, 4..16; OSR_W = $clog2(OSR)
//  DIV_RST  650  prescaler reload after reset (100 MHz, 9600 baud, x16 => 651 clk per os tick)
// PORTS
//  clk        in   1      system clock
//  rst_n      in   1      asynchronous active-low reset
//  en         in   1      1 = generate ticks; 0 = hold counters, outputs 0
//  div_i      in   DIV_W  new prescaler reload value (period in clk minus 1)
//  div_load   in   1      1-cycle strobe: capture div_i
//  rx_resync  in   1      1-cycle strobe: restart RX oversample phase (start-bit edge)
//  rx_os_tick out  1      1-cycle strobe at OSR x baud
//  rx_mid     out  1      coincides with rx_os_tick when RX phase count = OSR/2 (bit centre)
//  tx_tick    out  1      1-cycle strobe at 1x baud
//  div_q      out  DIV_W  currently active divisor (readback)
// BEHAVIOUR
//  Reset: div_q=DIV_RST; all counters 0; rx_os_tick=rx_mid=tx_tick=0.
//  All outputs are registered. Strobes are high for exactly one clk.
//  Prescaler: pre_cnt counts 0..div_q. The wrap cycle (pre_cnt==div_q) asserts the next-cycle
//    os strobe and sets pre_cnt to 0. Period = div_q+1 clk.
//  TX stage: tx_os counts os strobes 0..OSR-1. tx_tick fires when tx_os wraps.
//    Period = OSR*(div_q+1) clk. The first tx_tick comes OSR*(div_q+1) clk after reset/enable-from-idle.
//  RX stage: rx_os (OSR_W bits) counts os strobes mod OSR, independent of tx_os.
//    rx_mid = rx_os_tick & (rx_os==OSR/2).
//  rx_resync: next cycle, rx_os=0 and a private rx prescaler phase (rx_pre) =0.
//    rx_os_tick derives from rx_pre, not pre_cnt, so TX timing is unaffected.
//    The first rx_mid after resync comes (OSR/2+1)*(div_q+1) clk later.
//  div_load: div_i is captured into div_q and all counters (pre/rx_pre/tx_os/rx_os) clear next cycle.
//    No strobe occurs in that cycle. New period applies from that point.
//  div_i==0 on load: clamp to 1 (minimum period 2 clk). div_q never reads 0.
//  Simultaneous div_load + rx_resync: div_load wins (superset clear).
//  Simultaneous strobe-due + div_load/rx_resync: the clear wins and the strobe is suppressed.
//  en=0: counters freeze, strobes forced 0, div_load still honoured.
//    On en 0->1, counting resumes from the frozen values.
//  Reset mid-operation: asynchronous clear to reset values. Strobes may be cut mid-period; no partial pulse.
//  Arithmetic: all counters unsigned. Compare on ==. No wrap beyond the reload value.
//    Any counter value above div_q (possible only transiently, never after a load) wraps on the next
//    cycle via >= compare.
// STRUCTURE
//  Package uart_pkg: DIV_W, OSR defaults, DIV_RST, OSR_W function, baud-divisor helper constant
//    (CLK_HZ/(BAUD*OSR)-1).
//  Sub-module uart_tick_div (DIV_W): load/clear/en, programmable wrap counter, registered strobe out.
//    Instantiated twice (TX prescaler, RX prescaler).
//  OSR counters and rx_mid decode are inline.
// TESTING
//  1 Reset, en=1, defaults -> rx_os_tick every 651 clk; tx_tick every 10416 clk; rx_mid every 10416 clk.
//  2 div_load with div_i=3 mid-period -> next cycle no strobe, counters 0.
//    rx_os_tick period 4 clk; tx_tick period 64 clk; div_q=3.
//  3 div_load with div_i=0 -> div_q=1; rx_os_tick period 2 clk; tx_tick period 32 clk.
//  4 div_q=9: rx_resync at arbitrary cycle t -> rx_mid at t+1+90 clk.
//    tx_tick cadence unchanged (160 clk).
//  5 en low for 37 clk mid-period -> no strobes while low.
//    Next tx_tick delayed by exactly 37 clk. div_load during en=0 takes effect.
//  6 rst_n asserted mid-period, asynchronous to clk -> outputs 0 immediately, div_q=DIV_RST.
//    After release, behaviour matches scenario 1; same-cycle div_load+rx_resync matches div_load alone.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared constants and helpers for the UART baud-rate generator.
// Revision : 1.0
// ============================================================================
package uart_pkg;

    localparam int unsigned c_div_w   = 16;
    localparam int unsigned c_osr     = 16;
    localparam int unsigned c_div_rst = 650;

    localparam int unsigned c_clk_hz  = 100_000_000;
    localparam int unsigned c_baud    = 9600;

    // Prescaler reload for the nominal clock/baud pair (period in clk minus 1).
    localparam int unsigned c_baud_div = c_clk_hz / (c_baud * c_osr) - 1;

    function automatic int unsigned osr_w(input int unsigned osr);
        return $clog2(osr);
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_tick_div.sv
`default_nettype none
// ============================================================================
// Module   : uart_tick_div
// Brief    : Programmable wrap counter (0..div) with a registered 1-clk strobe.
// Revision : 1.0
// ============================================================================
module uart_tick_div
    import uart_pkg::*;
#(
    parameter int unsigned DIV_W = c_div_w
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             wrap,
    output logic             strobe
);

    logic [DIV_W-1:0] r_cnt;
    logic             r_strobe;
    logic             w_at_end;

    // >= lets an out-of-range count recover on the next cycle.
    assign w_at_end = (r_cnt >= div);
    assign wrap     = en & ~clr & w_at_end;
    assign strobe   = r_strobe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= wrap;
            if (clr) begin
                r_cnt <= '0;
            end else if (en) begin
                r_cnt <= w_at_end ? '0 : r_cnt + 1'b1;
            end
        end
    end

endmodule : uart_tick_div
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_gen
// Brief    : Runtime-programmable baud tick generator (RX oversample + TX 1x).
// Revision : 1.0
// ============================================================================
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned DIV_W   = c_div_w,
    parameter int unsigned OSR     = c_osr,
    parameter int unsigned DIV_RST = c_div_rst
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DIV_W-1:0] div_i,
    input  logic             div_load,
    input  logic             rx_resync,
    output logic             rx_os_tick,
    output logic             rx_mid,
    output logic             tx_tick,
    output logic [DIV_W-1:0] div_q
);

    localparam int unsigned          c_osr_w   = osr_w(OSR);
    localparam logic [c_osr_w-1:0]   c_os_last = c_osr_w'(OSR - 1);
    localparam logic [c_osr_w-1:0]   c_os_mid  = c_osr_w'(OSR / 2);

    logic [DIV_W-1:0]   r_div_q;
    logic [DIV_W-1:0]   w_div_new;
    logic [c_osr_w-1:0] r_tx_os;
    logic [c_osr_w-1:0] r_rx_os;
    logic               r_tx_tick;
    logic               r_rx_mid;

    logic               w_tx_clr;
    logic               w_rx_clr;
    logic               w_tx_wrap;
    logic               w_tx_strobe;
    logic               w_rx_wrap;
    logic               w_rx_strobe;

    // A zero divisor would give a 1-clk period with a permanently high strobe.
    assign w_div_new = (div_i == '0) ? DIV_W'(1) : div_i;

    assign w_tx_clr  = div_load;
    assign w_rx_clr  = div_load | rx_resync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_q <= DIV_W'(DIV_RST);
        end else if (div_load) begin
            r_div_q <= w_div_new;
        end
    end

    uart_tick_div #(
        .DIV_W (DIV_W)
    ) u_tx_pre (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .clr    (w_tx_clr),
        .div    (r_div_q),
        .wrap   (w_tx_wrap),
        .strobe (w_tx_strobe)
    );

    uart_tick_div #(
        .DIV_W (DIV_W)
    ) u_rx_pre (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .clr    (w_rx_clr),
        .div    (r_div_q),
        .wrap   (w_rx_wrap),
        .strobe (w_rx_strobe)
    );

    // OSR counters advance on the visible strobe, so during the wrap cycle they
    // still hold the number of strobes already issued in the current baud bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_os   <= '0;
            r_tx_tick <= 1'b0;
        end else begin
            r_tx_tick <= w_tx_wrap & (r_tx_os == c_os_last);
            if (w_tx_clr) begin
                r_tx_os <= '0;
            end else if (w_tx_strobe) begin
                r_tx_os <= (r_tx_os == c_os_last) ? '0 : r_tx_os + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_os  <= '0;
            r_rx_mid <= 1'b0;
        end else begin
            r_rx_mid <= w_rx_wrap & (r_rx_os == c_os_mid);
            if (w_rx_clr) begin
                r_rx_os <= '0;
            end else if (w_rx_strobe) begin
                r_rx_os <= (r_rx_os == c_os_last) ? '0 : r_rx_os + 1'b1;
            end
        end
    end

    assign rx_os_tick = w_rx_strobe;
    assign rx_mid     = r_rx_mid;
    assign tx_tick    = r_tx_tick;
    assign div_q      = r_div_q;

endmodule : uart_baud_gen
`default_nettype wire

// File: tb/tb_uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_baud_gen
// Brief    : Self-checking bench for uart_baud_gen against a cycle-count model.
// Revision : 1.0
// ============================================================================
module tb_uart_baud_gen;

    localparam int unsigned DW   = 16;
    localparam int unsigned OSRV = 16;
    localparam int unsigned DRST = 650;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [DW-1:0] div_i;
    logic          div_load;
    logic          rx_resync;
    logic          rx_os_tick;
    logic          rx_mid;
    logic          tx_tick;
    logic [DW-1:0] div_q;

    int n_vec = 0;
    int n_err = 0;

    // Model: count enabled clock edges since the last clear; strobes are due
    // whenever the count hits a multiple of the relevant period.
    int unsigned m_d;
    int unsigned m_ntx;
    int unsigned m_nrx;
    logic        e_os;
    logic        e_mid;
    logic        e_tx;

    uart_baud_gen #(
        .DIV_W   (DW),
        .OSR     (OSRV),
        .DIV_RST (DRST)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .div_i      (div_i),
        .div_load   (div_load),
        .rx_resync  (rx_resync),
        .rx_os_tick (rx_os_tick),
        .rx_mid     (rx_mid),
        .tx_tick    (tx_tick),
        .div_q      (div_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_d   = DRST;
        m_ntx = 0;
        m_nrx = 0;
        e_os  = 1'b0;
        e_mid = 1'b0;
        e_tx  = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        e_os  = 1'b0;
        e_mid = 1'b0;
        e_tx  = 1'b0;
        if (div_load) begin
            m_d   = (div_i == 0) ? 1 : int'(div_i);
            m_ntx = 0;
            m_nrx = 0;
        end else begin
            if (en) begin
                m_ntx++;
                e_tx = ((m_ntx % (OSRV * (m_d + 1))) == 0);
            end
            if (rx_resync) begin
                m_nrx = 0;
            end else if (en) begin
                m_nrx++;
                if ((m_nrx % (m_d + 1)) == 0) begin
                    e_os  = 1'b1;
                    e_mid = (((m_nrx / (m_d + 1)) % OSRV) == OSRV / 2 + 1);
                end
            end
        end
        #1;
        chk("rx_os_tick", 32'(rx_os_tick), 32'(e_os));
        chk("rx_mid",     32'(rx_mid),     32'(e_mid));
        chk("tx_tick",    32'(tx_tick),    32'(e_tx));
        chk("div_q",      32'(div_q),      32'(m_d));
        div_load  = 1'b0;
        rx_resync = 1'b0;
    endtask

    task automatic run(input int unsigned n);
        for (int i = 0; i < int'(n); i++) step();
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_os"},  32'(rx_os_tick), 32'd0);
        chk({tag, "_mid"}, 32'(rx_mid),     32'd0);
        chk({tag, "_tx"},  32'(tx_tick),    32'd0);
        chk({tag, "_div"}, 32'(div_q),      32'(DRST));
    endtask

    initial begin
        rst_n     = 1'b0;
        en        = 1'b0;
        div_i     = '0;
        div_load  = 1'b0;
        rx_resync = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;

        // Defaults: 651-clk oversample, 10416-clk bit.
        run(2 * 10416 + 30);

        // Load 3 mid-period.
        run($urandom_range(1, 300));
        div_i = 16'd3; div_load = 1'b1;
        run(200);

        // Load 0 clamps to 1.
        div_i = 16'd0; div_load = 1'b1;
        run(100);

        // div 9 with resyncs at arbitrary points.
        div_i = 16'd9; div_load = 1'b1;
        run($urandom_range(5, 150));
        for (int k = 0; k < 3; k++) begin
            rx_resync = 1'b1;
            run($urandom_range(100, 400));
        end

        // en low for 37 clk, with a load while idle.
        run($urandom_range(1, 60));
        en = 1'b0;
        run(20);
        en = 1'b1;
        run(250);
        en = 1'b0;
        run(10);
        div_i = 16'($urandom_range(2, 12)); div_load = 1'b1;
        run(27);
        en = 1'b1;
        run(400);

        // Randomized mix of loads, resyncs and enable gaps.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 49) == 0) en = ~en;
            if ($urandom_range(0, 149) == 0) begin
                div_i    = 16'($urandom_range(0, 20));
                div_load = 1'b1;
            end
            if ($urandom_range(0, 59) == 0) rx_resync = 1'b1;
            step();
        end
        en = 1'b1;

        // Asynchronous reset mid-period.
        run($urandom_range(10, 100));
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_state("async_rst");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run(1400);

        // Same-cycle load + resync behaves like load alone.
        div_i = 16'd5; div_load = 1'b1; rx_resync = 1'b1;
        run(300);
        run($urandom_range(1, 20));
        rx_resync = 1'b1;
        run(300);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_uart_baud_gen
`default_nettype wire
